cordic_rotation: RTL

Iterative CORDIC engine in rotation mode, the inverse of the existing vectoring-mode datapath. It accepts a magnitude and a phase and produces the rotated vector (x_out, y_out) = G·x_in·(cos z_in, sin z_in), with G ≈ 1.6468. It performs one micro-rotation per clock under a start/done handshake. It sits beside the vectoring unit and shares its word formats, so a phase produced by one block can be fed directly to the other.

---
 rtl/cordic_rotation_pkg.sv | 46 ++++
 rtl/cordic_rotation_if.sv | 23 ++
 rtl/cordic_rotation_control.sv | 66 ++++++
 rtl/cordic_rotation.sv | 101 ++++++++++
 4 files changed

// File: rtl/cordic_rotation_pkg.sv
// Shared word formats, iteration constants and the arctangent table for the
// CORDIC rotation and vectoring units.
package cordic_rotation_pkg;

    localparam int WORD_WIDTH      = 16;
    localparam int PHASE_WIDTH     = 16;
    localparam int ITERATIONS      = 16;
    localparam int ITERATION_WIDTH = 5;

    // Two guard bits absorb the negation of the most-negative input and the CORDIC gain.
    localparam int ACC_WIDTH = WORD_WIDTH + 2;

    typedef logic signed [WORD_WIDTH-1:0]  word_t;
    typedef logic signed [ACC_WIDTH-1:0]   acc_t;
    typedef logic signed [PHASE_WIDTH-1:0] phase_t;
    typedef logic [ITERATION_WIDTH-1:0]    iter_t;

    // round(atan(2^-i) / pi * 2^(PHASE_WIDTH-1)) at PHASE_WIDTH = 16
    localparam phase_t ATAN_TABLE [0:15] = '{
        16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297,
        16'sd651,  16'sd326,  16'sd163,  16'sd81,
        16'sd41,   16'sd20,   16'sd10,   16'sd5,
        16'sd3,    16'sd1,    16'sd1,    16'sd0
    };

    function automatic phase_t atan_lut(input iter_t i);
        phase_t v;
        v = '0;
        if (i < iter_t'(ITERATIONS)) begin
            v = ATAN_TABLE[i[3:0]];
        end
        return v;
    endfunction

    // Clamp a guard-extended value into the output word range.
    function automatic word_t saturate(input acc_t v);
        word_t r;
        if ((&v[ACC_WIDTH-1:WORD_WIDTH-1]) || !(|v[ACC_WIDTH-1:WORD_WIDTH-1])) begin
            r = v[WORD_WIDTH-1:0];
        end else begin
            r = {v[ACC_WIDTH-1], {(WORD_WIDTH-1){~v[ACC_WIDTH-1]}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_rotation_if.sv
// Request/result bundle between a caller and the CORDIC rotation engine.
interface cordic_rotation_if;
    import cordic_rotation_pkg::*;

    logic   start;
    word_t  x_in;
    phase_t z_in;
    logic   busy;
    logic   done;
    word_t  x_out;
    word_t  y_out;

    modport master (
        output start, x_in, z_in,
        input  busy, done, x_out, y_out
    );

    modport slave (
        input  start, x_in, z_in,
        output busy, done, x_out, y_out
    );

endinterface

// File: rtl/cordic_rotation_control.sv
// Sequencer for the rotation engine: IDLE/RUN FSM, iteration counter and
// the load/step/finish strobes that steer the datapath.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold the last result
// ST_RUN   | cnt 0..ITERATIONS-1 micro-rotate, cnt == ITERATIONS registers result
module rotation_control
    import cordic_rotation_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    output logic  busy,
    output logic  done,
    output logic  load,
    output logic  step,
    output logic  finish,
    output iter_t iter
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0] state;
    iter_t      cnt;

    assign busy   = (state == ST_RUN);
    assign load   = (state == ST_IDLE) && start;
    assign step   = (state == ST_RUN) && (cnt < iter_t'(ITERATIONS));
    assign finish = (state == ST_RUN) && (cnt == iter_t'(ITERATIONS));
    assign iter   = cnt;

    // FSM, iteration counter and the single-cycle done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (cnt == iter_t'(ITERATIONS)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cordic_rotation.sv
// Iterative CORDIC rotation: (x_out, y_out) = G * x_in * (cos z_in, sin z_in),
// one micro-rotation per clock, with quadrant pre-rotation and saturated outputs.
module cordic_rotation
    import cordic_rotation_pkg::*;
(
    input logic              clk,
    input logic              rst,
    cordic_rotation_if.slave bus
);

    logic  load;
    logic  step;
    logic  finish;
    logic  busy;
    logic  done;
    iter_t iter;

    acc_t   x_r;
    acc_t   y_r;
    phase_t z_r;
    word_t  x_out_r;
    word_t  y_out_r;

    logic   quad;
    acc_t   x_ext;
    acc_t   x_load;
    phase_t z_load;
    acc_t   x_sh;
    acc_t   y_sh;
    acc_t   x_nxt;
    acc_t   y_nxt;
    phase_t z_nxt;
    phase_t atan_i;

    rotation_control u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (bus.start),
        .busy   (busy),
        .done   (done),
        .load   (load),
        .step   (step),
        .finish (finish),
        .iter   (iter)
    );

    // Load values: angles with |z| >= pi/2 are folded by pi and x is negated.
    always_comb begin
        quad   = bus.z_in[PHASE_WIDTH-1] ^ bus.z_in[PHASE_WIDTH-2];
        x_ext  = acc_t'(bus.x_in);
        x_load = quad ? -x_ext : x_ext;
        z_load = {bus.z_in[PHASE_WIDTH-1] ^ quad, bus.z_in[PHASE_WIDTH-2:0]};
    end

    // One micro-rotation, direction taken from the sign of the residual angle.
    always_comb begin
        x_sh   = x_r >>> iter;
        y_sh   = y_r >>> iter;
        atan_i = atan_lut(iter);
        if (!z_r[PHASE_WIDTH-1]) begin
            x_nxt = x_r - y_sh;
            y_nxt = y_r + x_sh;
            z_nxt = z_r - atan_i;
        end else begin
            x_nxt = x_r + y_sh;
            y_nxt = y_r - x_sh;
            z_nxt = z_r + atan_i;
        end
    end

    // Datapath registers; results are only exposed once all iterations are done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            x_out_r <= '0;
            y_out_r <= '0;
        end else begin
            if (load) begin
                x_r <= x_load;
                y_r <= '0;
                z_r <= z_load;
            end else if (step) begin
                x_r <= x_nxt;
                y_r <= y_nxt;
                z_r <= z_nxt;
            end
            if (finish) begin
                x_out_r <= saturate(x_r);
                y_out_r <= saturate(y_r);
            end
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.x_out = x_out_r;
    assign bus.y_out = y_out_r;

endmodule
